// File: rtl/spi_fifo_pkg.sv
// Shared SPI frame FIFO constants and FSM encodings for the transmit and receive FIFOs.
// No logic; latency and backpressure are defined by the modules that import it.
package spi_fifo_pkg;
    localparam int DSIZE   = 8;
    localparam int NBYTES  = 15;
    localparam int FRAME_W = NBYTES * DSIZE;
    localparam int DEPTH   = 32;
    localparam int ASIZE   = 5;

    typedef enum logic {
        L_IDLE,
        L_LOAD
    } load_state_e;

    typedef enum logic [1:0] {
        T_IDLE,
        T_ACTIVE,
        T_GAP
    } tx_state_e;
endpackage

// File: rtl/spi_fifo_mem.sv
// DEPTH x DSIZE byte RAM: write lands on the clock edge, read is combinational (zero latency).
// No flow control of its own; the owner guarantees it never writes into an occupied slot.
module spi_fifo_mem
    import spi_fifo_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ASIZE-1:0] wr_addr,
    input  logic [DSIZE-1:0] wr_data,
    input  logic [ASIZE-1:0] rd_addr,
    output logic [DSIZE-1:0] rd_data
);
    logic [DSIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/spi_tx_frame_fifo.sv
// Parallel 15-byte frame in, bytes out to the MOSI shifter with spi_cs framing; first byte valid 16 cycles after accept.
// frame_ready drops while loading or when a frame would not fit; tx_ready low holds tx_data/spi_cs stable.
module spi_tx_frame_fifo
    import spi_fifo_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic [DSIZE-1:0]   tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               spi_cs,
    output logic               frame_done,
    output logic [ASIZE:0]     level
);
    localparam logic [ASIZE:0] LOAD_MAX_LEVEL = (ASIZE+1)'(DEPTH - NBYTES);
    localparam logic [3:0]     LAST_BYTE      = 4'(NBYTES - 1);

    load_state_e        lstate_q, lstate_d;
    tx_state_e          tstate_q, tstate_d;
    logic [FRAME_W-1:0] stage_q, stage_d;
    logic [3:0]         lidx_q, lidx_d;
    logic [3:0]         tcnt_q, tcnt_d;
    logic [ASIZE-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ASIZE-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ASIZE:0]     level_q, level_d;
    logic [ASIZE:0]     avail_q, avail_d;
    logic               spi_cs_q, spi_cs_d;
    logic               tx_valid_q, tx_valid_d;
    logic               frame_done_q, frame_done_d;

    logic             wr_en, load_end, pop, last_pop;
    logic [DSIZE-1:0] wr_data, rd_data;

    assign wr_en       = (lstate_q == L_LOAD);
    assign wr_data     = stage_q[DSIZE*lidx_q +: DSIZE];
    assign load_end    = wr_en && (lidx_q == LAST_BYTE);
    assign pop         = tx_valid_q && tx_ready;
    assign last_pop    = pop && (tcnt_q == LAST_BYTE);
    assign frame_ready = (lstate_q == L_IDLE) && (level_q <= LOAD_MAX_LEVEL);

    spi_fifo_mem u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    always_comb begin
        lstate_d = lstate_q;
        stage_d  = stage_q;
        lidx_d   = lidx_q;
        case (lstate_q)
            L_IDLE: begin
                if (frame_valid && frame_ready) begin
                    stage_d  = frame_in;
                    lidx_d   = '0;
                    lstate_d = L_LOAD;
                end
            end
            L_LOAD: begin
                lidx_d = lidx_q + 1'b1;
                if (load_end) begin
                    lstate_d = L_IDLE;
                end
            end
            default: lstate_d = L_IDLE;
        endcase
    end

    // Leaving T_GAP and T_IDLE follow the same rule: start only on a fully loaded frame.
    always_comb begin
        tstate_d     = tstate_q;
        tcnt_d       = tcnt_q;
        spi_cs_d     = spi_cs_q;
        tx_valid_d   = tx_valid_q;
        frame_done_d = 1'b0;
        case (tstate_q)
            T_IDLE, T_GAP: begin
                if (avail_q != '0) begin
                    spi_cs_d   = 1'b1;
                    tx_valid_d = 1'b1;
                    tcnt_d     = '0;
                    tstate_d   = T_ACTIVE;
                end else begin
                    tstate_d   = T_IDLE;
                end
            end
            T_ACTIVE: begin
                if (pop) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                if (last_pop) begin
                    spi_cs_d     = 1'b0;
                    tx_valid_d   = 1'b0;
                    frame_done_d = 1'b1;
                    tstate_d     = T_GAP;
                end
            end
            default: tstate_d = T_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        case ({load_end, last_pop})
            2'b10:   avail_d = avail_q + 1'b1;
            2'b01:   avail_d = avail_q - 1'b1;
            default: avail_d = avail_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lstate_q     <= L_IDLE;
            tstate_q     <= T_IDLE;
            stage_q      <= '0;
            lidx_q       <= '0;
            tcnt_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            avail_q      <= '0;
            spi_cs_q     <= 1'b0;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            lstate_q     <= lstate_d;
            tstate_q     <= tstate_d;
            stage_q      <= stage_d;
            lidx_q       <= lidx_d;
            tcnt_q       <= tcnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            avail_q      <= avail_d;
            spi_cs_q     <= spi_cs_d;
            tx_valid_q   <= tx_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx_data    = tx_valid_q ? rd_data : '0;
    assign tx_valid   = tx_valid_q;
    assign spi_cs     = spi_cs_q;
    assign frame_done = frame_done_q;
    assign level      = level_q;
endmodule

// File: tb/tb_spi_tx_frame_fifo.sv
// Bench for spi_tx_frame_fifo: directed scenarios plus random traffic against a byte-queue reference model.
// Inputs change 1ns after the rising edge; the model samples and checks on the falling edge.
module tb_spi_tx_frame_fifo;
    logic         clk;
    logic         rst;
    logic [119:0] frame_in;
    logic         frame_valid;
    logic         frame_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         spi_cs;
    logic         frame_done;
    logic [5:0]   level;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 0;

    spi_tx_frame_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .spi_cs      (spi_cs),
        .frame_done  (frame_done),
        .level       (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bytes of accepted frames in send order, plus frame-level bookkeeping.
    logic [7:0] exp_q[$];
    int m_level, m_load, m_avail, m_sent;
    bit m_valid, m_done;

    always @(negedge clk) begin
        bit hs, pop, last, nxt_valid, m_ready;
        if (!rst) begin
            exp_q.delete();
            m_level = 0; m_load = 0; m_avail = 0; m_sent = 0;
            m_valid = 1'b0; m_done = 1'b0;
        end else begin
            m_ready = (m_load == 0) && (32 - m_level >= 15);
            chk("spi_cs", spi_cs, m_valid);
            chk("tx_valid", tx_valid, m_valid);
            chk("level", level, m_level);
            chk("frame_ready", frame_ready, m_ready);
            chk("frame_done", frame_done, m_done);
            if (m_valid) begin
                if (exp_q.size() == 0) chk("underrun", 1, 0);
                else                   chk("tx_data", tx_data, exp_q[0]);
            end else begin
                chk("tx_data_idle", tx_data, 0);
            end
            hs   = frame_valid && m_ready;
            pop  = m_valid && tx_ready;
            last = pop && (m_sent == 14);
            // cs falls on the last pop; rises the edge after a complete frame is seen waiting
            nxt_valid = m_valid ? !last : (m_avail != 0);
            m_done = last;
            if (m_load > 0) begin
                m_level++;
                m_load--;
                if (m_load == 0) m_avail++;
            end
            if (pop) begin
                m_level--;
                void'(exp_q.pop_front());
                m_sent = last ? 0 : m_sent + 1;
                if (last) m_avail--;
            end
            if (hs) begin
                m_load = 15;
                for (int k = 0; k < 15; k++) exp_q.push_back(frame_in[8*k +: 8]);
            end
            m_valid = nxt_valid;
        end
    end

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                2:       tx_ready = 1'b0;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic logic [119:0] seq_frame(input logic [7:0] base);
        logic [119:0] f;
        f = '0;
        for (int k = 0; k < 15; k++) f[8*k +: 8] = base + 8'(k);
        return f;
    endfunction

    function automatic logic [119:0] rand_frame();
        logic [119:0] f;
        f = '0;
        for (int k = 0; k < 15; k++) f[8*k +: 8] = 8'($urandom);
        return f;
    endfunction

    task automatic send_frame(input logic [119:0] f);
        int  b;
        logic acc;
        b = 0;
        frame_in    = f;
        frame_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = frame_ready;
            @(posedge clk);
            #1;
            b++;
        end while (!acc && b < 2000);
        frame_valid = 1'b0;
        frame_in    = rand_frame();
        if (!acc) chk("handshake_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (level == 0 && !tx_valid && frame_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", ok, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, h, pops, fd;
        rst         = 1'b0;
        frame_valid = 1'b0;
        frame_in    = '0;

        // Reset held while the host is already offering a frame.
        rdy_mode    = 3;
        frame_in    = seq_frame(8'h77);
        frame_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_spi_cs", spi_cs, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_tx_data", tx_data, 0);
        frame_valid = 1'b0;
        rst         = 1'b1;
        rdy_mode    = 0;
        @(negedge clk);
        chk("rst_frame_ready", frame_ready, 1);
        @(posedge clk);
        #1;

        // Single frame: first-byte latency and cs width.
        send_frame(seq_frame(8'h01));
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (tx_valid) begin
                n = i;
                break;
            end
        end
        chk("first_latency", n, 16);
        h = 0;
        while (spi_cs && h < 40) begin
            h++;
            @(posedge clk);
            #1;
        end
        chk("cs_width", h, 15);
        wait_idle();
        chk("single_level", level, 0);

        // Alternating backpressure.
        rdy_mode = 1;
        send_frame(seq_frame(8'h31));
        wait_idle();

        // Fill to two frames, third frame pending, then drain.
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send_frame(seq_frame(8'h41));
        send_frame(seq_frame(8'h51));
        for (int t = 0; t < 100 && level != 30; t++) @(negedge clk);
        chk("full_level", level, 30);
        @(posedge clk);
        #1;
        frame_in    = seq_frame(8'h61);
        frame_valid = 1'b1;
        @(negedge clk);
        chk("full_not_ready", frame_ready, 0);
        rdy_mode = 0;
        pops = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (frame_ready) break;
            if (tx_valid && tx_ready) pops++;
        end
        chk("pops_until_ready", pops, 13);
        chk("ready_level", level, 17);
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        wait_idle();

        // Back-to-back frames: one-cycle cs gap, two done pulses.
        rdy_mode = 0;
        send_frame(seq_frame(8'h10));
        send_frame(seq_frame(8'h20));
        fd = 0;
        for (int t = 0; t < 200 && fd < 2; t++) begin
            @(negedge clk);
            if (frame_done) begin
                fd++;
                chk("gap_cs_low", spi_cs, 0);
                @(negedge clk);
                chk("gap_cs_after", spi_cs, (fd == 1) ? 1 : 0);
            end
        end
        chk("done_pulses", fd, 2);
        wait_idle();

        // Reset after five bytes of a frame have gone out.
        send_frame(seq_frame(8'h50));
        pops = 0;
        for (int t = 0; t < 100 && pops < 5; t++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) pops++;
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_spi_cs", spi_cs, 0);
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_level", level, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        send_frame(seq_frame(8'hA0));
        for (int t = 0; t < 40 && !tx_valid; t++) @(negedge clk);
        chk("after_rst_first_byte", tx_data, 8'hA0);
        wait_idle();

        // Random frames under random backpressure.
        rdy_mode = 3;
        for (int i = 0; i < 6; i++) send_frame(rand_frame());
        wait_idle();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
